// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue: circular buffer with occupancy count,
// almost-full watermark and a serialising-issue FSM gated by ex_idle.
module decode_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 64,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq_valid,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       enq_serialize,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_data,
  input  logic                       deq_ready,
  input  logic                       stall_queue,
  input  logic                       flush_queue,
  input  logic                       ex_idle,
  output logic                       is_queue_full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] NORMAL   = 2'd0;
  localparam logic [1:0] SER_WAIT = 2'd1;
  localparam logic [1:0] SER_BUSY = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  ser_flag;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              not_empty;
  logic              head_ser;
  logic              enq_fire;
  logic              deq_fire;

  assign not_empty     = (count != '0);
  assign head_ser      = ser_flag[rd_ptr];
  assign is_queue_full = (count == CW'(DEPTH));
  assign almost_full   = (count >= CW'(AFULL_THRESH));
  // No pass-through when full: a same-cycle dequeue does not open a slot.
  assign enq_ready     = !is_queue_full;
  assign enq_fire      = enq_valid & enq_ready & !flush_queue;
  assign deq_fire      = deq_valid & deq_ready;
  assign deq_data      = mem[rd_ptr];

  always_comb begin
    deq_valid  = 1'b0;
    state_next = state;
    case (state)
      NORMAL: begin
        deq_valid = not_empty & !stall_queue & !flush_queue & !head_ser;
        if (not_empty && head_ser) state_next = SER_WAIT;
      end
      SER_WAIT: begin
        deq_valid = not_empty & ex_idle & !stall_queue & !flush_queue;
        if (deq_fire) state_next = SER_BUSY;
      end
      SER_BUSY: begin
        // The issue edge is handled in SER_WAIT, so ex_idle here is post-issue.
        if (ex_idle) state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
    if (flush_queue) state_next = NORMAL;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      ser_flag <= '0;
    end else if (enq_fire) begin
      mem[wr_ptr]      <= enq_data;
      ser_flag[wr_ptr] <= enq_serialize;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= NORMAL;
    end else if (flush_queue) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= NORMAL;
    end else begin
      state <= state_next;
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue (DEPTH=4): fill/drain, wrap, simultaneous
// enq/deq, flush, serialising issue and mid-operation reset.
module tb_decode_issue_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enq_valid = 1'b0;
  logic [63:0] enq_data = '0;
  logic        enq_serialize = 1'b0;
  logic        enq_ready;
  logic        deq_valid;
  logic [63:0] deq_data;
  logic        deq_ready = 1'b0;
  logic        stall_queue = 1'b0;
  logic        flush_queue = 1'b0;
  logic        ex_idle = 1'b1;
  logic        is_queue_full;
  logic        almost_full;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  decode_issue_queue #(.DEPTH(4), .DATA_W(64), .AFULL_THRESH(3)) dut (
    .CLK(CLK), .RST(RST),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_serialize(enq_serialize),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
    .stall_queue(stall_queue), .flush_queue(flush_queue), .ex_idle(ex_idle),
    .is_queue_full(is_queue_full), .almost_full(almost_full), .count(count)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic s);
    enq_valid = 1'b1; enq_data = d; enq_serialize = s;
    tick();
    enq_valid = 1'b0; enq_serialize = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (enq_ready !== 1'b1) $display("FAIL rst_enq_ready got %b exp 1", enq_ready); else passed++;
    total++; if (deq_valid !== 1'b0) $display("FAIL rst_deq_valid got %b exp 0", deq_valid); else passed++;
    total++; if (deq_data !== 64'h0) $display("FAIL rst_deq_data got %h exp 0", deq_data); else passed++;
    total++; if (is_queue_full !== 1'b0) $display("FAIL rst_full got %b exp 0", is_queue_full); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL rst_afull got %b exp 0", almost_full); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    deq_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(64'(i), 1'b0);
      total++; if (count !== 3'(i)) $display("FAIL fill_count got %0d exp %0d", count, i); else passed++;
      total++; if (almost_full !== (i >= 3)) $display("FAIL fill_afull got %b exp %b", almost_full, i >= 3); else passed++;
      total++; if (is_queue_full !== (i == 4)) $display("FAIL fill_full got %b exp %b", is_queue_full, i == 4); else passed++;
      total++; if (enq_ready !== (i != 4)) $display("FAIL fill_enq_ready got %b exp %b", enq_ready, i != 4); else passed++;
    end
    deq_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (deq_valid !== 1'b1) $display("FAIL drain_valid got %b exp 1", deq_valid); else passed++;
      total++; if (deq_data !== 64'(i)) $display("FAIL drain_data got %h exp %h", deq_data, 64'(i)); else passed++;
      tick();
      total++; if (count !== 3'(4 - i)) $display("FAIL drain_count got %0d exp %0d", count, 4 - i); else passed++;
    end
    deq_ready = 1'b0;
    total++; if (deq_valid !== 1'b0) $display("FAIL drain_empty_valid got %b exp 0", deq_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic en [10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    logic dq [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    int   cn [10] = '{1, 2, 3, 2, 2, 1, 2, 3, 3, 2};
    int wk = 0;
    int rk = 0;
    for (int i = 0; i < 10; i++) begin
      enq_valid = en[i]; enq_data = 64'h10 + 64'(wk); deq_ready = dq[i];
      #1;
      if (dq[i]) begin
        total++; if (deq_valid !== 1'b1) $display("FAIL wrap_valid step %0d got %b exp 1", i, deq_valid); else passed++;
        total++; if (deq_data !== 64'h10 + 64'(rk)) $display("FAIL wrap_data step %0d got %h exp %h", i, deq_data, 64'h10 + 64'(rk)); else passed++;
        rk++;
      end
      if (en[i]) wk++;
      tick();
      total++; if (count !== 3'(cn[i])) $display("FAIL wrap_count step %0d got %0d exp %0d", i, count, cn[i]); else passed++;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++; if (deq_data !== 64'h10 + 64'(rk)) $display("FAIL wrap_tail got %h exp %h", deq_data, 64'h10 + 64'(rk)); else passed++;
      rk++;
      tick();
    end
    deq_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL wrap_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [63:0] tail [3] = '{64'hA3, 64'hA4, 64'hA5};
    push(64'hA1, 1'b0);
    push(64'hA2, 1'b0);
    enq_valid = 1'b1; enq_data = 64'hA3; deq_ready = 1'b1;
    #1;
    total++; if (deq_data !== 64'hA1) $display("FAIL sim_head got %h exp a1", deq_data); else passed++;
    tick();
    total++; if (count !== 3'd2) $display("FAIL sim_count got %0d exp 2", count); else passed++;
    total++; if (deq_data !== 64'hA2) $display("FAIL sim_head_adv got %h exp a2", deq_data); else passed++;
    deq_ready = 1'b0;
    enq_data = 64'hA4; tick();
    enq_data = 64'hA5; tick();
    total++; if (is_queue_full !== 1'b1) $display("FAIL sim_full got %b exp 1", is_queue_full); else passed++;
    enq_data = 64'hBAD; deq_ready = 1'b1;
    #1;
    total++; if (enq_ready !== 1'b0) $display("FAIL full_enq_ready got %b exp 0", enq_ready); else passed++;
    tick();
    enq_valid = 1'b0;
    total++; if (count !== 3'd3) $display("FAIL full_deq_count got %0d exp 3", count); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (deq_data !== tail[i]) $display("FAIL full_drain got %h exp %h", deq_data, tail[i]); else passed++;
      tick();
    end
    deq_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL full_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_flush();
    push(64'hC1, 1'b0);
    push(64'hC2, 1'b0);
    push(64'hC3, 1'b0);
    flush_queue = 1'b1; enq_valid = 1'b1; enq_data = 64'hDEAD;
    #1;
    total++; if (deq_valid !== 1'b0) $display("FAIL flush_cycle_valid got %b exp 0", deq_valid); else passed++;
    tick();
    flush_queue = 1'b0; enq_valid = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
    total++; if (deq_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", deq_valid); else passed++;
    total++; if (enq_ready !== 1'b1) $display("FAIL flush_enq_ready got %b exp 1", enq_ready); else passed++;
    push(64'hE1, 1'b0);
    deq_ready = 1'b1;
    total++; if (deq_data !== 64'hE1) $display("FAIL flush_next_data got %h exp e1", deq_data); else passed++;
    tick();
    deq_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL flush_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_serialize();
    ex_idle = 1'b1;
    push(64'h0A, 1'b0);
    push(64'h05, 1'b1);
    push(64'h0B, 1'b0);
    deq_ready = 1'b1;
    total++; if (deq_valid !== 1'b1 || deq_data !== 64'h0A) $display("FAIL ser_a got v=%b d=%h exp v=1 d=0a", deq_valid, deq_data); else passed++;
    tick();
    ex_idle = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (deq_valid !== 1'b0) $display("FAIL ser_hold cyc %0d got %b exp 0", i, deq_valid); else passed++;
      tick();
    end
    total++; if (count !== 3'd2) $display("FAIL ser_hold_count got %0d exp 2", count); else passed++;
    ex_idle = 1'b1;
    #1;
    total++; if (deq_valid !== 1'b1 || deq_data !== 64'h05) $display("FAIL ser_issue got v=%b d=%h exp v=1 d=05", deq_valid, deq_data); else passed++;
    tick();
    ex_idle = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (deq_valid !== 1'b0) $display("FAIL ser_busy cyc %0d got %b exp 0", i, deq_valid); else passed++;
      tick();
    end
    ex_idle = 1'b1;
    #1;
    total++; if (deq_valid !== 1'b0) $display("FAIL ser_idle_cycle got %b exp 0", deq_valid); else passed++;
    tick();
    total++; if (deq_valid !== 1'b1 || deq_data !== 64'h0B) $display("FAIL ser_b got v=%b d=%h exp v=1 d=0b", deq_valid, deq_data); else passed++;
    tick();
    deq_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL ser_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_reset_midop();
    ex_idle = 1'b1;
    push(64'h55, 1'b1);
    push(64'h66, 1'b0);
    push(64'h77, 1'b0);
    deq_ready = 1'b1;
    total++; if (deq_valid !== 1'b1 || deq_data !== 64'h55) $display("FAIL mid_ser_issue got v=%b d=%h exp v=1 d=55", deq_valid, deq_data); else passed++;
    tick();
    deq_ready = 1'b0; ex_idle = 1'b0;
    tick();
    total++; if (count !== 3'd2) $display("FAIL mid_pre_count got %0d exp 2", count); else passed++;
    RST = 1'b1;
    #1;
    total++; if (count !== 3'd0) $display("FAIL mid_rst_count got %0d exp 0", count); else passed++;
    total++; if (enq_ready !== 1'b1) $display("FAIL mid_rst_enq_ready got %b exp 1", enq_ready); else passed++;
    total++; if (deq_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", deq_valid); else passed++;
    total++; if (deq_data !== 64'h0) $display("FAIL mid_rst_data got %h exp 0", deq_data); else passed++;
    total++; if (is_queue_full !== 1'b0 || almost_full !== 1'b0) $display("FAIL mid_rst_flags got full=%b afull=%b exp 0 0", is_queue_full, almost_full); else passed++;
    #2;
    RST = 1'b0;
    tick();
    push(64'h99, 1'b0);
    deq_ready = 1'b1;
    total++; if (deq_valid !== 1'b1 || deq_data !== 64'h99) $display("FAIL mid_post_issue got v=%b d=%h exp v=1 d=99", deq_valid, deq_data); else passed++;
    tick();
    deq_ready = 1'b0;
    total++; if (count !== 3'd0) $display("FAIL mid_post_count got %0d exp 0", count); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_serialize();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised decode-to-execute instruction queue for the multi-stage pipeline. It generalises the fixed decode queue into a configurable-depth FIFO and adds an almost-full watermark, an occupancy count and a serialising-issue mode. Serialising entries (vsetvl, CSR-class ops) issue alone and block further issue until execute reports idle. The queue sits between the decode stage and execute; the hazard unit drives stall/flush and observes full/almost-full.

## Interface
- DEPTH, 4: entry count; power of two, ≥2.
- DATA_W, 64: payload width (decoded instruction bundle).
- AFULL_THRESH, DEPTH-1: almost_full asserts when count ≥ this value; range 1..DEPTH.

Ports (one clock; reset asynchronous, active-high):
- CLK  in  1  clock, rising edge.
- RST  in  1  async active-high reset.
- enq_valid  in  1  decode presents an entry.
- enq_data  in  DATA_W  entry payload.
- enq_serialize  in  1  entry must issue alone.
- enq_ready  out  1  queue can accept; equals !is_queue_full.
- deq_valid  out  1  head entry eligible to issue.
- deq_data  out  DATA_W  head payload.
- deq_ready  in  1  execute accepts the head.
- stall_queue  in  1  hazard stall: blocks dequeue only.
- flush_queue  in  1  hazard flush: discard all entries.
- ex_idle  in  1  execute holds no in-flight serialising op.
- is_queue_full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AFULL_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer: payload + serialize flag per slot; rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; count is a separate register.
- Enqueue fires on enq_valid & enq_ready & !flush_queue.
- Dequeue fires on deq_valid & deq_ready; deq_valid already excludes stall and flush.
- deq_data = payload at rd_ptr, registered storage; no enq→deq bypass.
- count_next = count + enq_fire − deq_fire. Simultaneous enq and deq leave count unchanged and both pointers advance.
- FSM, states NORMAL, SER_WAIT, SER_BUSY:
  - NORMAL: deq_valid = (count≠0) & !stall_queue & !flush_queue & !head_ser. If count≠0 and head_ser, go to SER_WAIT.
  - SER_WAIT: deq_valid = ex_idle & !stall_queue & !flush_queue. On deq_fire, go to SER_BUSY.
  - SER_BUSY: deq_valid = 0. Return to NORMAL when ex_idle=1 is sampled in any cycle after the issue cycle.
  - Contract: execute drops ex_idle the cycle after accepting a serialising op.
  - Non-serialising entries queued behind a serialising one wait in SER_BUSY.
- flush_queue has the highest priority:
  - Pointers and count go to 0.
  - FSM goes to NORMAL.
  - An enqueue presented in the same cycle is dropped.
  - Storage contents are not cleared.
- stall_queue does not block enqueue when space exists.

## Timing
- Reset (async, immediate): count=0, pointers=0, FSM=NORMAL, storage=0.
- Outputs while RST is high: enq_ready=1, deq_valid=0, deq_data=0, is_queue_full=0, almost_full=0.
- Reset asserted mid-operation discards all entries and any SER_BUSY state.
- Enqueue-to-dequeue latency is 1 cycle: an entry written at edge N is visible on deq_valid/deq_data after edge N.
- Throughput is 1 enq + 1 deq per cycle in NORMAL.
- When full, enq_ready=0 even if a dequeue fires the same cycle; no pass-through on full.
- Empty: deq_valid=0. deq_data shows the stale slot and is don't-care.
- Serialising op minimum issue gap: issue at edge N, SER_BUSY from N. The earliest next issue is the cycle after ex_idle is seen high at edge ≥N+1.
- is_queue_full, almost_full and count are registered-derived and change only on clock edges.
- Flush at edge N: count=0, deq_valid=0 after N, and enq_ready=1 after N.

## Test plan
- Fill/drain, DEPTH=4: 4 enqueues with no deq_ready → count=4, is_queue_full=1, enq_ready=0; almost_full asserts at count=3. Then 4 dequeues return data 0x1..0x4 in order and count returns to 0.
- Wrap-around: 10 interleaved enq/deq with queue depth oscillating between 1 and 3 → data order preserved across pointer wrap; count never exceeds 3.
- Simultaneous: at count=2, enq and deq in the same cycle → count stays 2 and the head advances. At count=4 with enq_valid and deq fire → enq rejected, count=3.
- Flush: count=3 with enq_valid in the flush cycle → next cycle count=0, deq_valid=0, enq_ready=1, and the flushed-cycle payload never appears.
- Serialise: queue [A, S(ser), B], ex_idle low after S issues.
  - S is held in SER_WAIT until ex_idle=1.
  - After S issues, B has deq_valid=0 for 3 cycles while ex_idle=0.
  - B issues 1 cycle after ex_idle rises.
- Reset mid-op: RST pulsed while in SER_BUSY with count=2 → all outputs take their reset values immediately. After RST release, a new enqueue issues in NORMAL.
